// File: rtl/uart_proto_pkg.sv
// Shared definitions for the UART register-access protocol.
// Host-side test models import the same command codes, markers and response lengths.
package uart_proto_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] ACK_DEFAULT  = 8'h5A;
    localparam logic [7:0] NAK_DEFAULT  = 8'hEE;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam logic [1:0] LEN_WR_ACK = 2'd2;
    localparam logic [1:0] LEN_RD_ACK = 2'd3;
    localparam logic [1:0] LEN_NAK    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_EXEC,
        ST_RD_WAIT,
        ST_RESP
    } parse_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_HI,
        TX_LO
    } tx_state_t;

    // Only a WRITE frame carries a data byte; every other command folds in zero.
    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return cmd ^ addr ^ ((cmd == CMD_WRITE) ? data : 8'h00);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? 8'hFF : val + 8'd1;
    endfunction

endpackage

// File: rtl/uart_resp_tx_seq.sv
// Response byte sequencer: hands up to three buffered bytes to the UART transmitter,
// one write strobe per byte, pacing on the transmitter busy handshake.
module uart_resp_tx_seq
    import uart_proto_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] len,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    input  logic [7:0] byte2,
    input  logic       tx_busy_i,
    output logic       tx_wr_o,
    output logic [7:0] tx_dat_o,
    output logic       done
);

    tx_state_t       state;
    logic [2:0][7:0] byte_buf;
    logic [1:0]      idx;
    logic [1:0]      len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            byte_buf <= '0;
            idx      <= 2'd0;
            len_q    <= 2'd0;
            tx_wr_o  <= 1'b0;
            tx_dat_o <= 8'h00;
            done     <= 1'b0;
        end else begin
            tx_wr_o <= 1'b0;
            done    <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        byte_buf <= {byte2, byte1, byte0};
                        len_q    <= len;
                        idx      <= 2'd0;
                        state    <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (!tx_busy_i) begin
                        tx_wr_o  <= 1'b1;
                        tx_dat_o <= byte_buf[idx];
                        state    <= TX_HI;
                    end
                end
                TX_HI: begin
                    if (tx_busy_i) begin
                        state <= TX_LO;
                    end
                end
                TX_LO: begin
                    if (!tx_busy_i) begin
                        if (idx == len_q - 2'd1) begin
                            done  <= 1'b1;
                            state <= TX_IDLE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= TX_SEND;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Slave end of the host register-access protocol over the UART byte link:
// parses WRITE/READ frames, drives the register bus, answers with ACK/NAK frames.
//
//  state       | meaning
//  ST_IDLE     | hunting for SYNC, other bytes dropped
//  ST_GET_CMD  | waiting for command byte
//  ST_GET_ADDR | waiting for address byte
//  ST_GET_DATA | waiting for write data byte (WRITE only)
//  ST_GET_CHK  | waiting for checksum; bus strobe issued on the way out
//  ST_EXEC     | choose response, count NAKs
//  ST_RD_WAIT  | latch read data returned by the register block
//  ST_RESP     | response sequencer running, incoming bytes dropped
module uart_cmd_responder
    import uart_proto_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
    parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_busy_i,
    input  logic [7:0] rx_byte_i,
    input  logic       tx_busy_i,
    output logic       tx_wr_o,
    output logic [7:0] tx_dat_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o,
    output logic [7:0] err_cnt_o
);

    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    parse_state_t     state;
    logic             rx_busy_q;
    logic             rx_stb;
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_get;
    logic             tmo_hit;
    logic [7:0]       cmd_q;
    logic [7:0]       addr_q;
    logic [7:0]       data_q;
    logic             cmd_known;
    logic             chk_ok;
    logic             exec_ok;
    logic             tx_start;
    logic [1:0]       resp_len;
    logic [7:0]       resp_b0;
    logic [7:0]       resp_b1;
    logic [7:0]       resp_b2;
    logic             tx_done;

    assign rx_stb    = rx_busy_q & ~rx_busy_i;
    assign in_get    = (state == ST_GET_CMD) || (state == ST_GET_ADDR) ||
                       (state == ST_GET_DATA) || (state == ST_GET_CHK);
    // A byte landing on the expiry cycle wins and reloads the timer.
    assign tmo_hit   = in_get && !rx_stb && (tmo_cnt == '0);
    assign cmd_known = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ);
    assign chk_ok    = cmd_known && (frame_chk(cmd_q, addr_q, data_q) == rx_byte_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rx_busy_q   <= 1'b0;
            tmo_cnt     <= '0;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            exec_ok     <= 1'b0;
            reg_addr_o  <= 8'h00;
            reg_wdata_o <= 8'h00;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            busy_o      <= 1'b0;
            err_cnt_o   <= 8'h00;
            tx_start    <= 1'b0;
            resp_len    <= 2'd0;
            resp_b0     <= 8'h00;
            resp_b1     <= 8'h00;
            resp_b2     <= 8'h00;
        end else begin
            rx_busy_q <= rx_busy_i;
            reg_we_o  <= 1'b0;
            reg_re_o  <= 1'b0;
            tx_start  <= 1'b0;

            if (rx_stb) begin
                tmo_cnt <= TMO_LOAD;
            end else if (in_get && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end

            if (tmo_hit) begin
                state     <= ST_IDLE;
                busy_o    <= 1'b0;
                err_cnt_o <= sat_inc8(err_cnt_o);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_stb && rx_byte_i == SYNC_BYTE) begin
                            state  <= ST_GET_CMD;
                            busy_o <= 1'b1;
                        end
                    end
                    ST_GET_CMD: begin
                        if (rx_stb) begin
                            cmd_q <= rx_byte_i;
                            state <= ST_GET_ADDR;
                        end
                    end
                    ST_GET_ADDR: begin
                        if (rx_stb) begin
                            addr_q <= rx_byte_i;
                            data_q <= 8'h00;
                            state  <= (cmd_q == CMD_WRITE) ? ST_GET_DATA : ST_GET_CHK;
                        end
                    end
                    ST_GET_DATA: begin
                        if (rx_stb) begin
                            data_q <= rx_byte_i;
                            state  <= ST_GET_CHK;
                        end
                    end
                    ST_GET_CHK: begin
                        if (rx_stb) begin
                            exec_ok <= chk_ok;
                            if (chk_ok) begin
                                reg_addr_o <= addr_q;
                                if (cmd_q == CMD_WRITE) begin
                                    reg_wdata_o <= data_q;
                                    reg_we_o    <= 1'b1;
                                end else begin
                                    reg_re_o <= 1'b1;
                                end
                            end
                            state <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        if (!exec_ok) begin
                            resp_b0   <= NAK_BYTE;
                            resp_b1   <= cmd_q;
                            resp_b2   <= 8'h00;
                            resp_len  <= LEN_NAK;
                            tx_start  <= 1'b1;
                            err_cnt_o <= sat_inc8(err_cnt_o);
                            state     <= ST_RESP;
                        end else if (cmd_q == CMD_READ) begin
                            state <= ST_RD_WAIT;
                        end else begin
                            resp_b0  <= ACK_BYTE;
                            resp_b1  <= 8'h00;
                            resp_b2  <= 8'h00;
                            resp_len <= LEN_WR_ACK;
                            tx_start <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                    ST_RD_WAIT: begin
                        resp_b0  <= ACK_BYTE;
                        resp_b1  <= reg_rdata_i;
                        resp_b2  <= reg_rdata_i;
                        resp_len <= LEN_RD_ACK;
                        tx_start <= 1'b1;
                        state    <= ST_RESP;
                    end
                    ST_RESP: begin
                        if (tx_done) begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    uart_resp_tx_seq u_tx_seq (
        .clk       (clk),
        .rst       (rst),
        .start     (tx_start),
        .len       (resp_len),
        .byte0     (resp_b0),
        .byte1     (resp_b1),
        .byte2     (resp_b2),
        .tx_busy_i (tx_busy_i),
        .tx_wr_o   (tx_wr_o),
        .tx_dat_o  (tx_dat_o),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: frame-level model of expected bus strobes,
// response bytes and error count, checked every cycle, plus literal spot checks.
module tb_uart_cmd_responder;

    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_busy_i = 1'b0;
    logic [7:0] rx_byte_i = 8'h00;
    logic       tx_busy_i = 1'b0;
    logic       tx_wr_o;
    logic [7:0] tx_dat_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_rdata_i = 8'h00;
    logic       busy_o;
    logic [7:0] err_cnt_o;

    int vecs = 0;
    int errs = 0;
    int model_err = 0;
    int we_count = 0;
    int re_count = 0;
    int busy_cnt = 0;
    int base = 0;
    logic force_busy = 1'b0;
    logic re_prev = 1'b0;
    logic prev_we = 1'b0;
    logic prev_re = 1'b0;
    logic [7:0] rd_val = 8'h00;
    logic [7:0] sat_addr;
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_we[$];
    logic [7:0]  exp_re[$];
    logic [7:0]  tx_log[$];

    uart_cmd_responder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_busy_i   (rx_busy_i),
        .rx_byte_i   (rx_byte_i),
        .tx_busy_i   (tx_busy_i),
        .tx_wr_o     (tx_wr_o),
        .tx_dat_o    (tx_dat_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] log_at(input int i);
        if (i < tx_log.size()) return tx_log[i];
        return 8'hxx;
    endfunction

    // Environment (UART transmitter, register block) and per-cycle compare.
    always @(negedge clk) begin
        reg_rdata_i = re_prev ? rd_val : 8'hC3;
        re_prev = reg_re_o;
        if (tx_wr_o) begin
            tx_log.push_back(tx_dat_o);
            busy_cnt = 6;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy_i = force_busy || (busy_cnt > 0);
        if (!rst) begin
            if (reg_we_o) begin
                we_count++;
                check("we_one_cycle", {15'd0, prev_we}, 16'd0);
                check("we_expected", 16'(exp_we.size() != 0), 16'd1);
                if (exp_we.size() != 0) check("we_addr_data", {reg_addr_o, reg_wdata_o}, exp_we.pop_front());
            end
            if (reg_re_o) begin
                re_count++;
                check("re_one_cycle", {15'd0, prev_re}, 16'd0);
                check("re_expected", 16'(exp_re.size() != 0), 16'd1);
                if (exp_re.size() != 0) check("re_addr", {8'h00, reg_addr_o}, {8'h00, exp_re.pop_front()});
            end
            if (tx_wr_o) begin
                check("tx_expected", 16'(exp_tx.size() != 0), 16'd1);
                if (exp_tx.size() != 0) check("tx_byte", {8'h00, tx_dat_o}, {8'h00, exp_tx.pop_front()});
            end
        end
        prev_we = reg_we_o;
        prev_re = reg_re_o;
    end

    // Frame-level expectation: what the responder must do with one complete frame.
    task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr,
                               input logic [7:0] data, input logic [7:0] chk);
        logic [7:0] sum;
        logic ok;
        sum = (cmd == 8'h01) ? (cmd ^ addr ^ data) : (cmd ^ addr);
        ok  = (cmd == 8'h01 || cmd == 8'h02) && (sum == chk);
        if (ok && cmd == 8'h01) begin
            exp_we.push_back({addr, data});
            exp_tx.push_back(8'h5A);
            exp_tx.push_back(8'h00);
        end else if (ok) begin
            exp_re.push_back(addr);
            exp_tx.push_back(8'h5A);
            exp_tx.push_back(rd_val);
            exp_tx.push_back(rd_val);
        end else begin
            exp_tx.push_back(8'hEE);
            exp_tx.push_back(cmd);
            if (model_err < 255) model_err++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_byte_i = b;
        rx_busy_i = 1'b1;
        repeat (3) @(negedge clk);
        rx_busy_i = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [7:0] data, input logic [7:0] chk, input int slow);
        model_frame(cmd, addr, data, chk);
        send_byte(8'hA5, 2);
        send_byte(cmd, 2);
        send_byte(addr, slow);
        if (cmd == 8'h01) send_byte(data, 2);
        send_byte(chk, 2);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy_o !== 1'b0 || exp_tx.size() != 0 || busy_cnt != 0) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_done_in_time"}, 16'(n < 3000), 16'd1);
        check({name, "_tx_left"}, 16'(exp_tx.size()), 16'd0);
        check({name, "_we_left"}, 16'(exp_we.size()), 16'd0);
        check({name, "_re_left"}, 16'(exp_re.size()), 16'd0);
        check({name, "_err_cnt"}, {8'h00, err_cnt_o}, 16'(model_err));
        exp_tx.delete();
        exp_we.delete();
        exp_re.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx_wr", {15'd0, tx_wr_o}, 16'd0);
        check("rst_tx_dat", {8'h00, tx_dat_o}, 16'd0);
        check("rst_addr", {8'h00, reg_addr_o}, 16'd0);
        check("rst_wdata", {8'h00, reg_wdata_o}, 16'd0);
        check("rst_we", {15'd0, reg_we_o}, 16'd0);
        check("rst_re", {15'd0, reg_re_o}, 16'd0);
        check("rst_busy", {15'd0, busy_o}, 16'd0);
        check("rst_err", {8'h00, err_cnt_o}, 16'd0);
        rst = 1'b0;

        // 1: write
        base = tx_log.size();
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D, 2);
        wait_idle("t1");
        check("t1_we_count", 16'(we_count), 16'd1);
        check("t1_tx0", {8'h00, log_at(base)}, 16'h005A);
        check("t1_tx1", {8'h00, log_at(base + 1)}, 16'h0000);
        check("t1_wdata", {8'h00, reg_wdata_o}, 16'h003C);

        // 2: read
        rd_val = 8'h77;
        base = tx_log.size();
        send_frame(8'h02, 8'h20, 8'h00, 8'h22, 2);
        wait_idle("t2");
        check("t2_we_count", 16'(we_count), 16'd1);
        check("t2_re_count", 16'(re_count), 16'd1);
        check("t2_tx0", {8'h00, log_at(base)}, 16'h005A);
        check("t2_tx1", {8'h00, log_at(base + 1)}, 16'h0077);
        check("t2_tx2", {8'h00, log_at(base + 2)}, 16'h0077);

        // 3: bad checksum
        base = tx_log.size();
        send_frame(8'h01, 8'h10, 8'h3C, 8'h00, 2);
        wait_idle("t3");
        check("t3_we_count", 16'(we_count), 16'd1);
        check("t3_tx0", {8'h00, log_at(base)}, 16'h00EE);
        check("t3_tx1", {8'h00, log_at(base + 1)}, 16'h0001);
        check("t3_err", {8'h00, err_cnt_o}, 16'd1);

        // 4: garbage before a valid read
        rd_val = 8'h3E;
        base = tx_log.size();
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h13, 2);
        send_frame(8'h02, 8'h05, 8'h00, 8'h07, 2);
        wait_idle("t4");
        check("t4_re_count", 16'(re_count), 16'd2);
        check("t4_tx_count", 16'(tx_log.size() - base), 16'd3);
        check("t4_tx1", {8'h00, log_at(base + 1)}, 16'h003E);

        // unknown command, read-length frame
        base = tx_log.size();
        send_frame(8'h07, 8'h10, 8'h00, 8'h17, 2);
        wait_idle("unk");
        check("unk_tx1", {8'h00, log_at(base + 1)}, 16'h0007);
        check("unk_err", {8'h00, err_cnt_o}, 16'd2);

        // SYNC arriving mid-response must be dropped
        send_frame(8'h01, 8'h22, 8'h10, 8'h33, 2);
        send_byte(8'hA5, 2);
        wait_idle("drop_a");
        send_frame(8'h02, 8'h05, 8'h00, 8'h07, 2);
        wait_idle("drop_b");
        check("drop_re_count", 16'(re_count), 16'd3);

        // 5: timeout after SYNC, CMD
        base = tx_log.size();
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        repeat (100) @(negedge clk);
        check("tmo_still_busy", {15'd0, busy_o}, 16'd1);
        repeat (150) @(negedge clk);
        model_err++;
        check("tmo_idle", {15'd0, busy_o}, 16'd0);
        check("tmo_err", {8'h00, err_cnt_o}, 16'd3);
        check("tmo_no_tx", 16'(tx_log.size() - base), 16'd0);
        // long but legal gap between bytes
        rd_val = 8'h6C;
        base = tx_log.size();
        send_frame(8'h02, 8'h20, 8'h00, 8'h22, 185);
        wait_idle("slow");
        check("slow_tx2", {8'h00, log_at(base + 2)}, 16'h006C);

        // 6: reset during the second response byte
        rd_val = 8'h91;
        base = tx_log.size();
        send_frame(8'h02, 8'h30, 8'h00, 8'h32, 2);
        begin
            int n;
            n = 0;
            while (tx_log.size() < base + 2 && n < 500) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("rst6_reached_byte2", 16'(n < 500), 16'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst6_busy", {15'd0, busy_o}, 16'd0);
        check("rst6_err", {8'h00, err_cnt_o}, 16'd0);
        check("rst6_tx_wr", {15'd0, tx_wr_o}, 16'd0);
        rst = 1'b0;
        exp_tx.delete();
        exp_we.delete();
        exp_re.delete();
        model_err = 0;
        repeat (100) @(negedge clk);
        check("rst6_no_more_tx", 16'(tx_log.size() - base), 16'd2);

        // transmitter held busy: response must wait
        force_busy = 1'b1;
        base = tx_log.size();
        send_frame(8'h01, 8'h44, 8'h5B, 8'h1E, 2);
        repeat (1000) @(negedge clk);
        check("hold_no_tx", 16'(tx_log.size() - base), 16'd0);
        check("hold_busy", {15'd0, busy_o}, 16'd1);
        force_busy = 1'b0;
        wait_idle("hold");
        check("hold_tx0", {8'h00, log_at(base)}, 16'h005A);
        check("hold_tx1", {8'h00, log_at(base + 1)}, 16'h0000);

        // error counter saturation
        for (int i = 0; i < 260; i++) begin
            sat_addr = 8'(i);
            send_frame(8'h01, sat_addr, 8'h00, sat_addr, 2);
            wait_idle("sat");
        end
        check("sat_err", {8'h00, err_cnt_o}, 16'h00FF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
